// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with an 8-bit Wishbone slave interface.
// Sends one command byte per write and reports busy/done/nack/timeout status.
module ps2_host_tx #(
  parameter int INHIBIT_CLKS = 12000,
  parameter int START_TOUT   = 1500000,
  parameter int PKT_TOUT     = 200000,
  parameter int TIMER_BITS   = 21,
  parameter int FILTER_LEN   = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_tgc_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit_o
);

  localparam int FILT_BITS = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FILT_BITS-1:0]  FILT_LAST    = FILT_BITS'(FILTER_LEN - 1);
  localparam logic [TIMER_BITS-1:0] INHIBIT_LAST = TIMER_BITS'(INHIBIT_CLKS - 1);
  localparam logic [TIMER_BITS-1:0] START_LAST   = TIMER_BITS'(START_TOUT - 1);
  localparam logic [TIMER_BITS-1:0] PKT_LAST     = TIMER_BITS'(PKT_TOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACKW, S_FIN, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [9:0]            shift_q, shift_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic                  dat_oe_q, dat_oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  nack_q, nack_d;
  logic                  tout_q, tout_d;
  logic                  tgc_q, tgc_d;

  logic [1:0]           clk_sync, dat_sync;
  logic                 clk_filt, clk_filt_prev;
  logic [FILT_BITS-1:0] filt_cnt;
  logic                 clk_s, dat_s, fall, accept, timer_sat, pkt_expired;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Idle bus level is high, so synchronizers and filter come out of reset at 1.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      clk_sync      <= 2'b11;
      dat_sync      <= 2'b11;
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      filt_cnt      <= '0;
    end else begin
      clk_sync      <= {clk_sync[0], ps2_clk_i};
      dat_sync      <= {dat_sync[0], ps2_dat_i};
      clk_filt_prev <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall        = clk_filt_prev & ~clk_filt;
  assign accept      = wb_ack_o & wb_stb_i & wb_cyc_i & wb_we_i & (state_q == S_IDLE);
  assign timer_sat   = &timer_q;
  assign pkt_expired = (timer_q == PKT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
    end else begin
      wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
    end
  end

  // Timeout checks precede fall handling so a coincident timeout wins.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_sat ? timer_q : timer_q + 1'b1;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = done_q;
    nack_d   = nack_q;
    tout_d   = tout_q;
    tgc_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d  = '0;
        dat_oe_d = 1'b0;
        if (accept) begin
          shift_d  = {1'b1, ~^wb_dat_i, wb_dat_i};
          bitcnt_d = 4'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          nack_d   = 1'b0;
          tout_d   = 1'b0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == INHIBIT_LAST) begin
          dat_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (timer_q == START_LAST) begin
          tout_d   = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end else if (fall) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitcnt_d = 4'd1;
          timer_d  = '0;
          state_d  = S_XFER;
        end
      end
      S_XFER: begin
        if (pkt_expired) begin
          tout_d   = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end else if (fall) begin
          dat_oe_d = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = S_ACKW;
          end
        end
      end
      S_ACKW: begin
        if (pkt_expired) begin
          tout_d   = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end else if (fall) begin
          nack_d  = dat_s;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (pkt_expired) begin
          tout_d   = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end else if (clk_filt && dat_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tgc_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        tgc_d    = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      tout_q   <= 1'b0;
      tgc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      tout_q   <= tout_d;
      tgc_q    <= tgc_d;
    end
  end

  assign wb_dat_o     = {busy_q, done_q, nack_q, tout_q, 4'b0000};
  assign wb_tgc_o     = tgc_q;
  assign ps2_clk_oe   = (state_q == S_INHIBIT);
  assign ps2_dat_oe   = dat_oe_q;
  assign rx_inhibit_o = (state_q != S_IDLE);

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the opposite direction of the existing PS/2 keyboard receiver. It sends command bytes to the keyboard, e.g. LED set (0xED) or reset (0xFF).
- It is an 8-bit Wishbone I/O slave (one write register, one status register) clocked on the 100 MHz keyboard clock.
- Open-drain pad control is exported as pull-low enables; the top level builds the tristates and shares the lines with the receiver.
- rx_inhibit_o tells the receiver to ignore the bus while a frame is in flight.

Parameters:
- INHIBIT_CLKS, 12000: clocks the clock line is held low before the request (120 us @100 MHz).
- START_TOUT, 1500000: max clocks from request until the first device falling edge (15 ms).
- PKT_TOUT, 200000: max clocks from the first falling edge to the ACK sample (2 ms).
- TIMER_BITS, 21: width of the shared timer; must hold every count above.
- FILTER_LEN, 4: consecutive equal samples needed to accept a new filtered level on ps2_clk_i.

Ports:
- wb_clk_i  in  1  100 MHz clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_dat_i  in  8  byte to transmit.
- wb_dat_o  out 8  status {busy, done, nack, tout, 4'b0}.
- wb_we_i  in  1  1 = write (transmit), 0 = read (status).
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out 1  single-cycle acknowledge.
- wb_tgc_o  out 1  one-cycle completion pulse (success or error).
- ps2_clk_i  in  1  raw PS/2 clock pad level (asynchronous).
- ps2_dat_i  in  1  raw PS/2 data pad level (asynchronous).
- ps2_clk_oe  out 1  1 = pull clock line low.
- ps2_dat_oe  out 1  1 = pull data line low.
- rx_inhibit_o  out 1  1 while state is not IDLE.

Behaviour:
- Reset: state IDLE. wb_ack_o, wb_tgc_o, ps2_clk_oe, ps2_dat_oe and rx_inhibit_o are 0. Status bits are 0. Timer and bit counter are 0.
- Reset mid-frame releases both lines on the next clock edge.
- Input conditioning:
  - Both pads pass through 2-FF synchronizers.
  - Clock is filtered: the filtered level changes only after FILTER_LEN equal consecutive samples.
  - fall = filtered clock 1 -> 0 (one-cycle pulse). Data is sampled from its synchronized value.
- Wishbone:
  - wb_ack_o <= stb & cyc & ~wb_ack_o: one ack per access, one cycle of latency.
  - wb_dat_o is registered status and is valid with the ack.
  - A write is accepted only when state is IDLE, on the ack cycle. Acceptance clears done, nack and tout.
  - A write while busy is acked and ignored; status is unchanged.
  - Reads have no side effects.
- Frame register: on accept, load shift[9:0] = {1'b1, ~^byte, byte}, i.e. stop, odd parity, data LSB first. Set busy.
- States and transitions:
  - IDLE: lines released. Accept -> INHIBIT with timer = 0.
  - INHIBIT: ps2_clk_oe = 1. When timer reaches INHIBIT_CLKS-1, set ps2_dat_oe = 1 (start bit) and go to REQ with timer = 0.
  - REQ: ps2_clk_oe = 0, ps2_dat_oe = 1.
    - fall: ps2_dat_oe = ~shift[0], shift right, bitcnt = 1, timer = 0, go to XFER.
    - timer reaches START_TOUT-1: go to ERR with tout set.
  - XFER: on each fall, ps2_dat_oe = ~shift[0], shift right, bitcnt++.
    - The fall with bitcnt = 9 drives the stop bit (line released). Then go to ACKW.
    - Falls 1..8 drive data bits, fall 9 drives parity, fall 10 drives stop.
  - ACKW: on fall (the 11th), sample data. If data = 1, set nack. Go to FIN.
  - FIN: wait until the filtered clock and the synchronized data are both 1. Then go to IDLE: busy = 0, done = 1, wb_tgc_o pulses for 1 cycle.
  - ERR: release both lines, busy = 0, wb_tgc_o pulses, go to IDLE. done stays 0.
- Packet timeout: in XFER, ACKW and FIN, if timer (started at the first fall) reaches PKT_TOUT-1, go to ERR with tout set.
- Timer saturates at all-ones and never wraps.
- Simultaneous events:
  - A fall on the same cycle as a timeout: the timeout wins.
  - Reset wins over everything.

Test Plan:
- Send 0xED, with the device model clocking at a 40 us period and ACK low.
  - ps2_clk_oe is low for exactly 12000 clocks.
  - Bits on the line are 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Status afterwards is 0x40 and wb_tgc_o pulses once.
- Send 0x00, with the device giving no ACK (data high at the 11th fall).
  - Parity bit is 1.
  - Status is 0x60 (done | nack).
- Write 0xFF, with the device never clocking.
  - After INHIBIT + 1500000 clocks, both lines are released.
  - Status is 0x10 (tout) and wb_tgc_o pulses.
- Device stops clocking after 5 falls.
  - ERR is reached 200000 clocks after the first fall.
  - tout is set and both oe outputs are 0.
- Write 0xAA mid-frame, then read status.
  - The write is acked and ignored: the frame on the line is unchanged.
  - Status reads 0x80.
- Assert wb_rst_i during XFER.
  - Next cycle: both oe = 0, rx_inhibit_o = 0, status 0x00.
- Inject a 2-sample glitch on ps2_clk_i.
  - No bit is shifted.
